// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the width helper for the shift counter.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Width of a counter that must be able to hold the value 'width' itself.
    function automatic int shcnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/usr_cell.sv
// One bit slice of the universal shift register: a 4:1 next-state mux
// (hold / from-left-neighbour / from-right-neighbour / load) feeding a flop.
module usr_cell
    import usr_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       shr_in,
    input  logic       shl_in,
    input  logic       d_in,
    output logic       q
);

    logic bit_d;
    logic bit_q;

    // Next-state select: clear beats enable, enable gates the mode mux.
    always_comb begin
        bit_d = bit_q;
        if (clr) begin
            bit_d = RESET_BIT;
        end else if (!en) begin
            bit_d = bit_q;
        end else begin
            case (mode)
                MODE_HOLD: bit_d = bit_q;
                MODE_SHR:  bit_d = shr_in;
                MODE_SHL:  bit_d = shl_in;
                MODE_LOAD: bit_d = d_in;
                default:   bit_d = bit_q;
            endcase
        end
    end

    // Storage flop with asynchronous active-low reset to this bit's reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q <= RESET_BIT;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q = bit_q;

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit hold / shift / rotate / load register with a saturating shift
// counter, a shifted-out bit and a one-cycle pulse when a full word has left.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            EN,
    input  logic                            CLR,
    input  logic [1:0]                      MODE,
    input  logic                            ROT,
    input  logic                            SI_R,
    input  logic                            SI_L,
    input  logic [WIDTH-1:0]                D,
    output logic [WIDTH-1:0]                Q,
    output logic                            SO,
    output logic [shcnt_width(WIDTH)-1:0]   SHCNT,
    output logic                            DONE
);

    localparam int             CW      = shcnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] shr_in_s;
    logic [WIDTH-1:0] shl_in_s;
    logic             so_d;
    logic             so_q;
    logic [CW-1:0]    cnt_d;
    logic [CW-1:0]    cnt_q;
    logic             done_d;
    logic             done_q;

    // Candidate next words for a right and a left shift; ROT closes the loop.
    always_comb begin
        shr_in_s = {(ROT ? q_q[0] : SI_R), q_q[WIDTH-1:1]};
        shl_in_s = {q_q[WIDTH-2:0], (ROT ? q_q[WIDTH-1] : SI_L)};
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            usr_cell #(
                .RESET_BIT (RESET_VAL[gi])
            ) u_cell (
                .clk    (CLK),
                .rst_n  (RST),
                .clr    (CLR),
                .en     (EN),
                .mode   (MODE),
                .shr_in (shr_in_s[gi]),
                .shl_in (shl_in_s[gi]),
                .d_in   (D[gi]),
                .q      (q_q[gi])
            );
        end
    endgenerate

    // Shift-out bit, saturating shift counter and the word-complete pulse.
    always_comb begin
        so_d   = so_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (CLR) begin
            so_d  = 1'b0;
            cnt_d = '0;
        end else if (!EN) begin
            so_d  = so_q;
            cnt_d = cnt_q;
        end else begin
            case (MODE)
                MODE_HOLD: begin
                    so_d = so_q;
                end
                MODE_SHR, MODE_SHL: begin
                    so_d = (MODE == MODE_SHR) ? q_q[0] : q_q[WIDTH-1];
                    if (cnt_q != CNT_MAX) begin
                        cnt_d  = cnt_q + CNT_ONE;
                        done_d = (cnt_q == (CNT_MAX - CNT_ONE));
                    end else begin
                        cnt_d  = cnt_q;
                        done_d = 1'b0;
                    end
                end
                MODE_LOAD: begin
                    cnt_d = '0;
                end
                default: begin
                    so_d = so_q;
                end
            endcase
        end
    end

    // Registers for SO, SHCNT and DONE; reset matches a synchronous clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            so_q   <= 1'b0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            so_q   <= so_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign Q     = q_q;
    assign SO    = so_q;
    assign SHCNT = cnt_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8, RESET_VAL=0): a bit-level
// reference model pushes expected results into a scoreboard queue when each
// step is driven; they are popped and compared one cycle later.
module tb_universal_shift_reg;

    typedef struct packed {
        logic [7:0] q;
        logic       so;
        logic [3:0] cnt;
        logic       done;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN = 1'b0;
    logic       CLR = 1'b0;
    logic [1:0] MODE = 2'b00;
    logic       ROT = 1'b0;
    logic       SI_R = 1'b0;
    logic       SI_L = 1'b0;
    logic [7:0] D = 8'h00;
    logic [7:0] Q;
    logic       SO;
    logic [3:0] SHCNT;
    logic       DONE;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    // Reference model state
    logic [7:0] m_q   = 8'h00;
    logic       m_so  = 1'b0;
    int         m_cnt = 0;
    logic       m_done = 1'b0;

    universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .MODE(MODE), .ROT(ROT),
        .SI_R(SI_R), .SI_L(SI_L), .D(D), .Q(Q), .SO(SO), .SHCNT(SHCNT), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q = 8'h00; m_so = 1'b0; m_cnt = 0; m_done = 1'b0;
    endtask

    // Drive one step, push the model's prediction, clock, pop and compare.
    task automatic step(input string tag, input logic en, input logic clr, input logic [1:0] mode,
                        input logic rot, input logic sir, input logic sil, input logic [7:0] d);
        logic [7:0] nq;
        exp_t e;
        exp_t got;
        EN = en; CLR = clr; MODE = mode; ROT = rot; SI_R = sir; SI_L = sil; D = d;
        m_done = 1'b0;
        if (clr) begin
            model_reset();
        end else if (en && mode == 2'b01) begin
            for (int i = 0; i < 7; i++) nq[i] = m_q[i+1];
            nq[7] = rot ? m_q[0] : sir;
            m_so = m_q[0]; m_q = nq;
            if (m_cnt < 8) begin m_cnt++; m_done = (m_cnt == 8); end
        end else if (en && mode == 2'b10) begin
            for (int i = 1; i < 8; i++) nq[i] = m_q[i-1];
            nq[0] = rot ? m_q[7] : sil;
            m_so = m_q[7]; m_q = nq;
            if (m_cnt < 8) begin m_cnt++; m_done = (m_cnt == 8); end
        end else if (en && mode == 2'b11) begin
            m_q = d; m_cnt = 0;
        end
        e.q = m_q; e.so = m_so; e.cnt = 4'(m_cnt); e.done = m_done;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            check({tag, " sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check({tag, " Q"},     {24'd0, Q},     {24'd0, got.q});
            check({tag, " SO"},    {31'd0, SO},    {31'd0, got.so});
            check({tag, " SHCNT"}, {28'd0, SHCNT}, {28'd0, got.cnt});
            check({tag, " DONE"},  {31'd0, DONE},  {31'd0, got.done});
        end
    endtask

    task automatic load(input logic [7:0] d);
        step("load", 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic shift(input string tag, input logic [1:0] mode, input logic rot,
                         input logic sir, input logic sil);
        step(tag, 1'b1, 1'b0, mode, rot, sir, sil, 8'h00);
    endtask

    logic [7:0] so_seq;

    initial begin
        // Reset state
        #12;
        check("reset Q", {24'd0, Q}, 32'h00);
        check("reset SO", {31'd0, SO}, 32'd0);
        check("reset SHCNT", {28'd0, SHCNT}, 32'd0);
        check("reset DONE", {31'd0, DONE}, 32'd0);
        @(negedge CLK); RST = 1'b1;

        // Async reset between edges
        load(8'hA5);
        check("pre-async Q", {24'd0, Q}, 32'hA5);
        shift("pre-async shr", 2'b01, 1'b0, 1'b0, 1'b0);
        #2 RST = 1'b0;
        #1;
        check("async Q", {24'd0, Q}, 32'h00);
        check("async SHCNT", {28'd0, SHCNT}, 32'd0);
        check("async SO", {31'd0, SO}, 32'd0);
        model_reset();
        @(negedge CLK); RST = 1'b1;

        // Shift right 8 times, then a 9th
        load(8'hA5);
        so_seq = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            shift("shr", 2'b01, 1'b0, 1'b0, 1'b0);
            check("shr SO seq", {31'd0, SO}, {31'd0, so_seq[7-i]});
            check("shr DONE only 8th", {31'd0, DONE}, (i == 7) ? 32'd1 : 32'd0);
        end
        check("shr final Q", {24'd0, Q}, 32'h00);
        shift("shr 9th", 2'b01, 1'b0, 1'b0, 1'b0);
        check("shr 9th SHCNT", {28'd0, SHCNT}, 32'd8);
        check("shr 9th DONE", {31'd0, DONE}, 32'd0);

        // Rotate left
        load(8'h81);
        shift("rol1", 2'b10, 1'b1, 1'b0, 1'b0);
        check("rol1 Q", {24'd0, Q}, 32'h03);
        check("rol1 SO", {31'd0, SO}, 32'd1);
        shift("rol2", 2'b10, 1'b1, 1'b0, 1'b0);
        check("rol2 Q", {24'd0, Q}, 32'h06);
        check("rol2 SO", {31'd0, SO}, 32'd0);
        step("hold", 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 8'hFF);

        // Shift left with serial fill from a cleared register
        step("clr", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        shift("shl1", 2'b10, 1'b0, 1'b0, 1'b1);
        check("shl1 Q", {24'd0, Q}, 32'h01);
        shift("shl2", 2'b10, 1'b0, 1'b0, 1'b1);
        check("shl2 Q", {24'd0, Q}, 32'h03);
        shift("shl3", 2'b10, 1'b0, 1'b0, 1'b1);
        check("shl3 Q", {24'd0, Q}, 32'h07);
        check("shl3 SHCNT", {28'd0, SHCNT}, 32'd3);

        // Enable and clear
        step("en0 load", 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'hFF);
        check("en0 Q held", {24'd0, Q}, 32'h07);
        step("en0 clr", 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'hFF);
        check("en0 clr Q", {24'd0, Q}, 32'h00);
        check("en0 clr SHCNT", {28'd0, SHCNT}, 32'd0);

        // Simultaneous events: clear beats load
        step("clr+load", 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h3C);
        check("clr+load Q", {24'd0, Q}, 32'h00);

        // Load after 5 shifts (mixed directions) restarts the count
        load(8'h5A);
        for (int i = 0; i < 5; i++)
            shift("pre5", (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b1, 1'b0);
        check("pre5 SHCNT", {28'd0, SHCNT}, 32'd5);
        load(8'hC3);
        check("reload SHCNT", {28'd0, SHCNT}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            shift("post8", 2'b10, 1'b1, 1'b0, 1'b0);
            check("post8 DONE", {31'd0, DONE}, (i == 7) ? 32'd1 : 32'd0);
        end
        check("post8 Q", {24'd0, Q}, 32'hC3);
        step("post hold", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        check("done width", {31'd0, DONE}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised successor to the lab's single-bit D flip-flop: a WIDTH-bit register that can hold, shift right, shift left, rotate or parallel-load under a 2-bit mode select. It also counts shifts since the last load and pulses when a full word has been shifted out. It is the storage and serialiser primitive for the lab's later datapath and serial-link exercises.

## Interface
- WIDTH, 8, register width in bits; legal range is WIDTH ≥ 2.
- RESET_VAL, 0, value of Q after reset and after synchronous clear.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- EN  in  1  clock enable for MODE actions; does not gate CLR.
- CLR  in  1  synchronous clear, active-high.
- MODE  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- ROT  in  1  1 = rotate; the shifted-out bit re-enters the opposite end instead of the serial input.
- SI_R  in  1  serial input entering the MSB on a right shift.
- SI_L  in  1  serial input entering the LSB on a left shift.
- D  in  WIDTH  parallel load data.
- Q  out  WIDTH  register contents.
- SO  out  1  bit shifted out by the most recent shift.
- SHCNT  out  $clog2(WIDTH+1)  shifts since the last load or clear; saturates at WIDTH.
- DONE  out  1  one-cycle pulse when SHCNT reaches WIDTH.

## Operation
- Priority, highest first: RST low, then CLR, then EN=0, then MODE.
- RST low: immediately and without a clock, Q=RESET_VAL, SO=0, SHCNT=0, DONE=0. State is held until RST returns high.
- CLR=1 (regardless of EN and MODE): Q, SO, SHCNT and DONE take the same values as under RST.
- EN=0 with CLR=0: Q, SO and SHCNT hold; DONE=0.
- MODE 00 hold: Q, SO and SHCNT hold; DONE=0.
- MODE 01 shift right: Q ← {ROT ? Q[0] : SI_R, Q[WIDTH-1:1]}; SO ← Q[0].
- MODE 10 shift left: Q ← {Q[WIDTH-2:0], ROT ? Q[WIDTH-1] : SI_L}; SO ← Q[WIDTH-1].
- MODE 11 load: Q ← D; SHCNT ← 0; DONE ← 0; SO holds.
- Shift counting: each shift or rotate does SHCNT ← min(SHCNT+1, WIDTH).
- DONE ← 1 only on the shift where SHCNT goes from WIDTH-1 to WIDTH; DONE is 0 in all other cycles.
- Once SHCNT is saturated at WIDTH, further shifts still move data but DONE stays 0 until the next load or clear.
- Changing the shift direction does not reset SHCNT.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Latency is one clock: Q, SO, SHCNT and DONE reflect the action sampled at edge n immediately after edge n.
- DONE is exactly one cycle wide.
- Asserting RST mid-shift abandons the word; SHCNT restarts from 0.
- RST deassertion is synchronised externally. The first edge with RST high performs the normal MODE action.

## Structure
- Shared package usr_pkg holds:
  - MODE encodings MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11;
  - a function computing the SHCNT width from WIDTH.
- One sub-module is natural: usr_cell, a single bit slice containing a 4:1 next-state mux and a flop with async active-low reset to a parameter bit. It is instantiated WIDTH times in a generate loop.
- The counter, DONE and SO logic live in the top module.

## Test plan
All scenarios use WIDTH=8 and RESET_VAL=0.
- Async reset: load 0xA5, then pull RST low between clock edges → Q=0x00, SHCNT=0 and SO=0 before the next edge.
- Shift right: load 0xA5; shift right 8 times with SI_R=0, ROT=0.
  - SO sequence is 1,0,1,0,0,1,0,1 and the final Q=0x00.
  - DONE is high only in the cycle after the 8th edge.
  - A 9th shift leaves SHCNT=8 with DONE=0.
- Rotate left: load 0x81; rotate left twice (ROT=1) → Q=0x03 then 0x06; SO=1 then 0.
- Shift left with serial fill: from 0x00, shift left 3 times with SI_L=1 → Q=0x01, 0x03, 0x07; SHCNT=1, 2, 3.
- Enable and clear: with EN=0, MODE=11 and D=0xFF → Q unchanged. With EN=0 and CLR=1 → Q=0x00, SHCNT=0.
- Simultaneous events: CLR=1 with MODE=11 and D=0x3C → Q=0x00. A load issued after 5 shifts resets SHCNT to 0, and DONE fires only after 8 further shifts.
